fast_bconv_ex_stream: RTL and testbench
=======================================

// Module: fast_bconv_ex_stream
// PURPOSE
// - Streaming, parametrised exact base conversion (B u Ba) -> q for the BFV/BEHZ multiply path.
// - Consumes one coefficient per beat: B_LEN residues in basis B followed by 1 residue in Ba.
// - Emits its q_LEN residues after a fixed 4-beat pipeline, with valid/ready backpressure.
// - Sits between the Bsk-domain tensor/scale stage and the q-domain relinearisation input.
//   It replaces the whole-polynomial, no-backpressure converter.
// PARAMETERS
// - B_LEN      default `B_BASIS_LEN   number of B primes (>=1)
// - Q_LEN      default `q_BASIS_LEN   number of q primes (>=1)
// - PW         default `RNS_PRIME_BITS  residue width; every prime is < 2**PW
// - N_SLOTS    default `N_SLOTS       coefficients per polynomial (frame length)
// PORTS
// - clk        in   1              rising-edge clock
// - reset      in   1              asynchronous, active-low reset
// - in_valid   in   1              input beat valid
// - in_ready   out  1              block accepts the beat this cycle
// - in_last    in   1              beat is the last coefficient of a polynomial
// - in_res     in   (B_LEN+1)*PW   residues; [0..B_LEN-1] = B, [B_LEN] = Ba
// - out_valid  out  1              output beat valid
// - out_ready  in   1              downstream accepts
// - out_last   out  1              in_last delayed alongside its data
// - out_res    out  Q_LEN*PW       residues mod q_j, each in [0,q_j)
// - frame_err  out  1              sticky slot-count error (FBCX_SLOT_CHECK_EN only)
// BEHAVIOUR
// - Reset (reset==0): all stage valids, out_valid, out_last and frame_err = 0.
//   Slot counter = 0. out_res = 0. in_ready = 1 one cycle after deassertion.
// - Handshake: a beat transfers when valid&&ready. Data/last stay stable while valid&&!ready.
// - Global stall: stall = out_valid && !out_ready; in_ready = !stall. All stages hold while stalled.
// - Bubbles propagate; no bubble collapsing needed. Throughput is 1 beat/cycle when out_ready=1.
// - Latency: a beat accepted at cycle t appears as out_valid at t+4 when there is no stall.
// - S1: register inputs. Compute v_i = x_i * z_i mod b_i, where z_i = (B/b_i)^-1 mod b_i.
// - S2 (fastBConv): xq_j = sum_i v_i*(B/b_i mod q_j) mod q_j, and xa = sum_i v_i*(B/b_i mod m_a) mod m_a.
//   Accumulate sums in PW*2+clog2(B_LEN) bits before the final mod.
// - S3: t = (xa - x_a) mod m_a, a non-negative mod. g = t * (B^-1 mod m_a) mod m_a.
//   Centre g: if g > m_a/2 then g = g - m_a (signed, PW+1 bits). Register g with xq_j.
// - S4: out_j = (xq_j - g*(B mod q_j)) mod q_j as a true mathematical mod, in [0,q_j).
//   Use signed 2*PW+2 bit intermediates. Register into out_res.
// - Boundaries: x = 0 gives all-zero output. Residue inputs >= prime are out of contract,
//   with undefined output but no lockup.
// - A reset mid-frame discards every in-flight beat. No partial output appears after reset.
// CONFIGURATION
// - FBCX_SLOT_CHECK_EN defined: an input slot counter runs 0..N_SLOTS-1.
//   It wraps to 0 on a transfer with in_last. frame_err is set, and sticky until reset,
//   if in_last arrives with counter != N_SLOTS-1, or if the counter is N_SLOTS-1 and in_last==0.
//   On error the counter resynchronises to 0 after in_last. Data flow is never blocked.
// - Macro undefined: no counter; frame_err tied to 0. in_last/out_last still pass through.
// STRUCTURE
// - Shared package (fhe_rns_pkg): B_BASIS, Ba_BASIS, q_BASIS, z_MOD_B, y_B_TO_q, y_B_TO_Ba,
//   binv_Ba_MOD_Ba, b_MOD_q, and rns_residue_t/wide_rns_residue_t.
// - Sub-module rns_mulmod (a*b mod p, parameter P) is used in S1, S2, S3 and S4.
// - Top: 4-stage valid/data pipeline plus the optional slot checker.
// TESTING (toy package: B={7,11}, Ba={13}, q={5,3}, N_SLOTS=4)
// - Reset: assert reset=0 mid-stream -> out_valid=0, frame_err=0; no stale beat after release.
// - x=0: in B=(0,0), Ba=0 -> out (0,0) at t+4.
// - x=40: B=(5,7), Ba=1 -> out (0,1). x=76: B=(6,10), Ba=11 -> out (1,1).
// - Streaming: 4 back-to-back beats, x=1,2,3,40 with in_last on the 4th ->
//   out (1,1),(2,2),(3,0),(0,1), 1/cycle, out_last only on the 4th.
// - Backpressure: hold out_ready=0 for 3 cycles mid-stream ->
//   in_ready=0 while stalled, out_res stable, no loss or duplication, order kept.
// - FBCX_SLOT_CHECK_EN: in_last on the 3rd beat -> frame_err=1 (sticky); next frame still converts correctly.

Source files
------------

// File: rtl/fhe_rns_pkg.sv
// Toy RNS basis constants for the BEHZ exact base conversion B={7,11}, Ba={13}, q={5,3}.
// Precomputed CRT factors are stored as int tables indexed [q prime][B prime].
package fhe_rns_pkg;
  localparam int B_BASIS_LEN    = 2;
  localparam int q_BASIS_LEN    = 2;
  localparam int RNS_PRIME_BITS = 4;
  localparam int FRAME_SLOTS    = 4;

  typedef logic [RNS_PRIME_BITS-1:0] rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS+$clog2(B_BASIS_LEN)-1:0] wide_rns_residue_t;

  localparam int B_BASIS [B_BASIS_LEN] = '{7, 11};
  localparam int Ba_BASIS               = 13;
  localparam int q_BASIS [q_BASIS_LEN] = '{5, 3};

  // (B/b_i)^-1 mod b_i with B = 77
  localparam int z_MOD_B [B_BASIS_LEN]                = '{2, 8};
  localparam int y_B_TO_q [q_BASIS_LEN][B_BASIS_LEN]  = '{'{1, 2}, '{2, 1}};
  localparam int y_B_TO_Ba [B_BASIS_LEN]              = '{11, 7};
  localparam int binv_Ba_MOD_Ba                       = 12;
  localparam int b_MOD_q [q_BASIS_LEN]                = '{2, 2};
endpackage

// File: rtl/rns_mulmod.sv
// Combinational modular product r = a*b mod P for a fixed prime P.
module rns_mulmod #(
  parameter int AW = 4,
  parameter int BW = 4,
  parameter int PW = 4,
  parameter int P  = 7
) (
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  output logic [PW-1:0] r_o
);
  localparam int PRW = AW + BW;
  localparam logic [PRW-1:0] P_W = PRW'(P);

  logic [PRW-1:0] prod;

  assign prod = a_i * b_i;
  assign r_o  = PW'(prod % P_W);
endmodule

// File: rtl/fast_bconv_ex_stream.sv
// Streaming exact base conversion (B u Ba) -> q: four-stage valid/ready pipeline with global stall.
// Define FBCX_SLOT_CHECK_EN to enable the input slot counter that drives the sticky frame_err.
module fast_bconv_ex_stream
  import fhe_rns_pkg::*;
#(
  parameter int B_LEN   = B_BASIS_LEN,
  parameter int Q_LEN   = q_BASIS_LEN,
  parameter int PW      = RNS_PRIME_BITS,
  parameter int N_SLOTS = FRAME_SLOTS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [(B_LEN+1)*PW-1:0] in_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [Q_LEN*PW-1:0]     out_res,
  output logic                    frame_err
);
  localparam int ACC_W = 2*PW + $clog2(B_LEN);
  localparam int D_W   = 2*PW + 2;
  localparam logic [ACC_W-1:0]     MA_ACC  = ACC_W'(Ba_BASIS);
  localparam logic [PW:0]          MA_U    = (PW+1)'(Ba_BASIS);
  localparam logic signed [PW:0]   MA_S    = (PW+1)'(Ba_BASIS);
  localparam logic [PW-1:0]        MA_HALF = PW'(Ba_BASIS / 2);

  logic stall;
  logic vld_p1_q, vld_p2_q, vld_p3_q, out_valid_q;
  logic last_p1_q, last_p2_q, last_p3_q, out_last_q;
  logic [(B_LEN+1)*PW-1:0] x_p1_q;
  logic [PW-1:0] v_p1 [B_LEN];
  logic [PW-1:0] ta_p1 [B_LEN];
  logic [PW-1:0] tq_p1 [Q_LEN][B_LEN];
  logic [PW-1:0] xq_p2_d [Q_LEN];
  logic [PW-1:0] xq_p2_q [Q_LEN];
  logic [PW-1:0] xq_p3_q [Q_LEN];
  logic [PW-1:0] xah_p2_d, xah_p2_q, xa_p2_q, g_p2;
  logic [ACC_W-1:0] acc_a;
  logic [PW:0] t_p2, g_abs_p3;
  logic signed [PW:0] g_p3_d, g_p3_q;
  logic [PW-1:0] out_d [Q_LEN];
  logic [Q_LEN*PW-1:0] out_res_d, out_res_q;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_res   = out_res_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      last_p1_q   <= 1'b0;
      last_p2_q   <= 1'b0;
      last_p3_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_res_q   <= '0;
    end else if (!stall) begin
      vld_p1_q    <= in_valid;
      last_p1_q   <= in_last;
      vld_p2_q    <= vld_p1_q;
      last_p2_q   <= last_p1_q;
      vld_p3_q    <= vld_p2_q;
      last_p3_q   <= last_p2_q;
      out_valid_q <= vld_p3_q;
      out_last_q  <= last_p3_q;
      out_res_q   <= out_res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      x_p1_q   <= in_res;
      xq_p2_q  <= xq_p2_d;
      xah_p2_q <= xah_p2_d;
      xa_p2_q  <= x_p1_q[B_LEN*PW +: PW];
      xq_p3_q  <= xq_p2_q;
      g_p3_q   <= g_p3_d;
    end
  end

  // ---- S1 -> S2: v_i = x_i*z_i mod b_i, then fastBConv into every q_j and into m_a
  for (genvar i = 0; i < B_LEN; i++) begin : g_b
    rns_mulmod #(.AW(PW), .BW(PW), .PW(PW), .P(B_BASIS[i])) u_v (
      .a_i(x_p1_q[i*PW +: PW]), .b_i(PW'(z_MOD_B[i])), .r_o(v_p1[i]));
    rns_mulmod #(.AW(PW), .BW(PW), .PW(PW), .P(Ba_BASIS)) u_ya (
      .a_i(v_p1[i]), .b_i(PW'(y_B_TO_Ba[i])), .r_o(ta_p1[i]));
    for (genvar j = 0; j < Q_LEN; j++) begin : g_q
      rns_mulmod #(.AW(PW), .BW(PW), .PW(PW), .P(q_BASIS[j])) u_yq (
        .a_i(v_p1[i]), .b_i(PW'(y_B_TO_q[j][i])), .r_o(tq_p1[j][i]));
    end
  end

  for (genvar j = 0; j < Q_LEN; j++) begin : g_acc
    localparam logic [ACC_W-1:0] QJ = ACC_W'(q_BASIS[j]);
    logic [ACC_W-1:0] acc;
    always_comb begin
      acc = '0;
      for (int i = 0; i < B_LEN; i++) acc = acc + ACC_W'(tq_p1[j][i]);
    end
    assign xq_p2_d[j] = PW'(acc % QJ);
  end

  always_comb begin
    acc_a = '0;
    for (int i = 0; i < B_LEN; i++) acc_a = acc_a + ACC_W'(ta_p1[i]);
  end
  assign xah_p2_d = PW'(acc_a % MA_ACC);

  // ---- S2 -> S3: overflow count g from the Ba discrepancy, centred into (-m_a/2, m_a/2]
  always_comb begin
    if (xah_p2_q >= xa_p2_q) t_p2 = {1'b0, xah_p2_q} - {1'b0, xa_p2_q};
    else                     t_p2 = {1'b0, xah_p2_q} + MA_U - {1'b0, xa_p2_q};
  end

  rns_mulmod #(.AW(PW+1), .BW(PW), .PW(PW), .P(Ba_BASIS)) u_g (
    .a_i(t_p2), .b_i(PW'(binv_Ba_MOD_Ba)), .r_o(g_p2));

  assign g_p3_d = (g_p2 > MA_HALF) ? $signed({1'b0, g_p2}) - MA_S : $signed({1'b0, g_p2});

  // ---- S3 -> S4: out_j = (xq_j - g*B) mod q_j, with |g|*B reduced first and the sign applied after
  assign g_abs_p3 = g_p3_q[PW] ? (PW+1)'(-g_p3_q) : g_p3_q;

  for (genvar j = 0; j < Q_LEN; j++) begin : g_out
    localparam logic signed [D_W-1:0] QS = D_W'(q_BASIS[j]);
    logic [PW-1:0] gp;
    logic signed [D_W-1:0] xs, gs, diff, res;
    rns_mulmod #(.AW(PW+1), .BW(PW), .PW(PW), .P(q_BASIS[j])) u_gb (
      .a_i(g_abs_p3), .b_i(PW'(b_MOD_q[j])), .r_o(gp));
    always_comb begin
      xs   = signed'(D_W'(xq_p3_q[j]));
      gs   = signed'(D_W'(gp));
      diff = g_p3_q[PW] ? xs + gs : xs - gs;
      if (diff[D_W-1])    res = diff + QS;
      else if (diff >= QS) res = diff - QS;
      else                 res = diff;
    end
    assign out_d[j] = PW'(res);
  end

  always_comb begin
    out_res_d = '0;
    for (int j = 0; j < Q_LEN; j++) out_res_d[j*PW +: PW] = out_d[j];
  end

`ifdef FBCX_SLOT_CHECK_EN
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(N_SLOTS - 1);

  logic in_fire;
  logic [SW-1:0] slot_q, slot_d;
  logic err_q, err_d;

  assign in_fire = in_valid && in_ready;

  // Counter holds at the last slot on an overrun so it realigns on the next in_last.
  always_comb begin
    slot_d = slot_q;
    err_d  = err_q;
    if (in_fire) begin
      if (in_last) begin
        slot_d = '0;
        if (slot_q != SLOT_MAX) err_d = 1'b1;
      end else if (slot_q == SLOT_MAX) begin
        err_d = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign frame_err = err_q;
`else
  // Without the checker only a degenerate zero-length frame setting can be flagged.
  assign frame_err = (N_SLOTS < 1);
`endif
endmodule

// File: tb/tb_fast_bconv_ex_stream.sv
// Bench for fast_bconv_ex_stream: directed table, stall/reset sequences and random frames
// scored against plain x mod q_j arithmetic with a cycle-accurate latency expectation.
module tb_fast_bconv_ex_stream;
  localparam int PW = 4;
`ifdef FBCX_SLOT_CHECK_EN
  localparam int SLOT_EN = 1;
`else
  localparam int SLOT_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [3*PW-1:0] in_res = '0;
  logic in_ready, out_valid, out_last, frame_err;
  logic [2*PW-1:0] out_res;

  fast_bconv_ex_stream dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_res(in_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_res(out_res), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct {
    int e0; int e1; bit last; int cyc; int stalls;
  } exp_t;

  typedef struct {
    int r0; int r1; int ra; int e0; int e1; bit last;
  } vec_t;

  exp_t exp_q[$];
  vec_t tab[8];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int cur_e0 = 0, cur_e1 = 0;
  bit prev_stall = 1'b0;
  bit rand_rdy = 1'b0;
  logic [2*PW-1:0] prev_res = '0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Samples mid-cycle, scores any transfer about to happen, then advances one clock.
  task automatic step(output bit fired);
    bit out_fire, stl;
    exp_t e;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    #2;
    fired    = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    stl      = out_valid && !out_ready;
    if (stl) begin
      stall_cnt++;
      chk("in_ready_stalled", int'(in_ready), 0);
      if (prev_stall) chk("out_res_hold", int'(out_res), int'(prev_res));
    end
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got res=%0h with nothing expected (cycle %0d)", out_res, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_q0", int'(out_res[PW-1:0]), e.e0);
        chk("out_q1", int'(out_res[2*PW-1:PW]), e.e1);
        chk("out_last", int'(out_last), int'(e.last));
        chk("latency", cyc - e.cyc, 4 + stall_cnt - e.stalls);
      end
    end
    if (fired) exp_q.push_back('{cur_e0, cur_e1, in_last, cyc, stall_cnt});
    prev_stall = stl;
    prev_res   = out_res;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int r0, input int r1, input int ra,
                      input int e0, input int e1, input bit last);
    bit f = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_res   = {PW'(ra), PW'(r1), PW'(r0)};
    in_last  = last;
    cur_e0   = e0;
    cur_e1   = e1;
    while (!f && n < 64) begin
      step(f);
      n++;
    end
    if (!f) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
    end
  endtask

  task automatic send_x(input int x, input bit last);
    send(x % 7, x % 11, x % 13, x % 5, x % 3, last);
  endtask

  task automatic idle(input int n);
    bit f;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step(f);
  endtask

  task automatic drain();
    bit f;
    int n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (exp_q.size() > 0 && n < 100) begin
      step(f);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    bit f;
    int idx, s0;
    tab[0] = '{0, 0, 0, 0, 0, 1'b0};
    tab[1] = '{5, 7, 1, 0, 1, 1'b0};
    tab[2] = '{6, 10, 11, 1, 1, 1'b0};
    tab[3] = '{5, 5, 5, 0, 2, 1'b1};
    tab[4] = '{1, 1, 1, 1, 1, 1'b0};
    tab[5] = '{2, 2, 2, 2, 2, 1'b0};
    tab[6] = '{3, 3, 3, 3, 0, 1'b0};
    tab[7] = '{5, 7, 1, 0, 1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_res", int'(out_res), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b1;
    idle(1);
    chk("in_ready_after_rst", int'(in_ready), 1);

    // isolated beats, then the same style of frame back-to-back
    for (int k = 0; k < 4; k++) begin
      send(tab[k].r0, tab[k].r1, tab[k].ra, tab[k].e0, tab[k].e1, tab[k].last);
      idle(5);
    end
    for (int k = 4; k < 8; k++)
      send(tab[k].r0, tab[k].r1, tab[k].ra, tab[k].e0, tab[k].e1, tab[k].last);
    drain();

    // three-cycle downstream stall with the pipeline full
    idx = 0;
    s0 = stall_cnt;
    for (int c = 0; c < 40 && (idx < 8 || exp_q.size() > 0); c++) begin
      out_ready = !(c >= 5 && c < 8);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        in_res  = {PW'((10 + idx) % 13), PW'((10 + idx) % 11), PW'((10 + idx) % 7)};
        in_last = (idx == 3 || idx == 7);
        cur_e0  = (10 + idx) % 5;
        cur_e1  = (10 + idx) % 3;
      end
      step(f);
      if (f) idx++;
    end
    out_ready = 1'b1;
    chk("bp_all_sent", idx, 8);
    chk("bp_stall_cycles", stall_cnt - s0, 3);
    drain();

    // reset in the middle of a frame discards everything in flight
    send_x(20, 1'b0);
    send_x(21, 1'b0);
    send_x(22, 1'b0);
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      chk("no_stale_beat", int'(out_valid), 0);
    end

    // random traffic, correctly framed, with random backpressure and gaps
    rand_rdy = 1'b1;
    for (int fr = 0; fr < 25; fr++) begin
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, 2));
        send_x($urandom_range(0, 76), b == 3);
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("frame_err_clean", int'(frame_err), 0);

    // short frame: in_last on the third beat, then a well-formed frame
    send_x(30, 1'b0);
    send_x(31, 1'b0);
    send_x(32, 1'b1);
    drain();
    chk("frame_err_short", int'(frame_err), SLOT_EN);
    for (int b = 0; b < 4; b++) send_x(50 + b, b == 3);
    drain();
    chk("frame_err_sticky", int'(frame_err), SLOT_EN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
